// File: rtl/bus_sample_latch_if.sv
// Bus-side signal bundle for bus_sample_latch: stall control, resolved lane
// values and driver flags in, phase clocks and sampled data out.
interface bus_sample_latch_if #(
    parameter int W = 8
);
    logic         run;
    logic [W-1:0] bus_in;
    logic [W-1:0] bus_driven;
    logic         phi1;
    logic         phi2;
    logic [W-1:0] data_out;
    logic         sample_valid;
    logic [W-1:0] float_hold;

    modport master (
        output run,
        output bus_in,
        output bus_driven,
        input  phi1,
        input  phi2,
        input  data_out,
        input  sample_valid,
        input  float_hold
    );

    modport slave (
        input  run,
        input  bus_in,
        input  bus_driven,
        output phi1,
        output phi2,
        output data_out,
        output sample_valid,
        output float_hold
    );
endinterface

// File: rtl/bus_sample_latch.sv
// phi1/phi2 sequencer with an end-of-phi2 bus sample latch.
// Define BUS_FLOAT_HOLD_EN to model charge retention on undriven lanes.
module bus_sample_latch #(
    parameter int W     = 8,
    parameter int DIV   = 2,
    parameter int DECAY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_sample_latch_if.slave  bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic {
        PHI1 = 1'b0,
        PHI2 = 1'b1
    } phase_e;

    phase_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           phi1_q, phi1_d;
    logic           phi2_q, phi2_d;
    logic           sv_q, sv_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [W-1:0]   fh_q, fh_d;
    logic           sample_s;

`ifdef BUS_FLOAT_HOLD_EN
    localparam int DW = (DECAY > 0) ? $clog2(DECAY + 1) : 1;
    localparam logic [DW-1:0] DCNT_INIT = DW'(DECAY);

    logic [W-1:0][DW-1:0] dcnt_q, dcnt_d;
`endif

    // Phase sequencer: half-phase counter and PHI1/PHI2 state, frozen while run is low
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_s = 1'b0;
        if (bus.run) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
                case (state_q)
                    PHI1: begin
                        state_d = PHI2;
                    end
                    PHI2: begin
                        state_d  = PHI1;
                        sample_s = 1'b1;
                    end
                    default: begin
                        state_d = PHI1;
                    end
                endcase
            end
        end else begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            sample_s = 1'b0;
        end
        // Both phase outputs come from the next state so they can never overlap.
        phi1_d = (state_d == PHI1);
        phi2_d = (state_d == PHI2);
        sv_d   = sample_s;
    end

    // Lane capture at the end of phi2
    always_comb begin
        hold_d = hold_q;
        fh_d   = fh_q;
`ifdef BUS_FLOAT_HOLD_EN
        dcnt_d = dcnt_q;
        if (sample_s) begin
            for (int i = 0; i < W; i++) begin
                if (bus.bus_driven[i]) begin
                    hold_d[i] = bus.bus_in[i];
                    dcnt_d[i] = DCNT_INIT;
                    fh_d[i]   = 1'b0;
                end else if (dcnt_q[i] != '0) begin
                    hold_d[i] = hold_q[i];
                    dcnt_d[i] = dcnt_q[i] - DW'(1);
                    fh_d[i]   = 1'b1;
                end else begin
                    // Charge has leaked away; the lane pull-up wins.
                    hold_d[i] = 1'b1;
                    dcnt_d[i] = '0;
                    fh_d[i]   = 1'b0;
                end
            end
        end else begin
            hold_d = hold_q;
            fh_d   = fh_q;
            dcnt_d = dcnt_q;
        end
`else
        if (sample_s) begin
            hold_d = bus.bus_in;
            fh_d   = '0;
        end else begin
            hold_d = hold_q;
            fh_d   = '0;
        end
`endif
    end

    // State, phase and sample registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PHI1;
            cnt_q   <= '0;
            phi1_q  <= 1'b1;
            phi2_q  <= 1'b0;
            sv_q    <= 1'b0;
            hold_q  <= '1;
            fh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi1_q  <= phi1_d;
            phi2_q  <= phi2_d;
            sv_q    <= sv_d;
            hold_q  <= hold_d;
            fh_q    <= fh_d;
        end
    end

`ifdef BUS_FLOAT_HOLD_EN
    // Per-lane retention counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end
`endif

    assign bus.phi1         = phi1_q;
    assign bus.phi2         = phi2_q;
    assign bus.sample_valid = sv_q;
    assign bus.data_out     = hold_q;
    assign bus.float_hold   = fh_q;

endmodule

// File: doc/bus_sample_latch.md
# bus_sample_latch

Downstream consumer of the open-drain bus lanes in the 6502 model. It takes the resolved wired-AND value of each lane plus a per-lane "any driver enabled" flag and runs the phi1/phi2 phase sequencer from a faster system clock. At the end of every phi2 it samples the bus into a registered data latch. With the hold feature compiled in, it also models dynamic charge retention on undriven lanes, which the lanes themselves do not provide.

## Interface

Parameters:
- `W`, default 8: number of bus lanes.
- `DIV`, default 2: system clocks per half-phase; legal range 1 to 16.
- `DECAY`, default 3: samples an undriven lane retains its charge before reading as pulled-up 1; 0 is legal.

Ports:
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `run` input, 1 bit: when high the phase sequencer advances; when low it freezes (RDY-style stall).
- `bus_in` input, W bits: resolved wired-AND value of each lane.
- `bus_driven` input, W bits: per lane, OR of that lane's driver enables.
- `phi1` output, 1 bit: registered; high during phase 1.
- `phi2` output, 1 bit: registered; high during phase 2; never high at the same time as phi1.
- `data_out` output, W bits: registered effective bus value captured at the last sample.
- `sample_valid` output, 1 bit: one-clock pulse marking a new `data_out`.
- `float_hold` output, W bits: per lane, 1 when the last sampled value came from retained charge rather than a driver.

## Operation

State and counter:
- Two-state sequencer, PHI1 and PHI2.
- Half-phase counter `cnt` runs 0 to DIV-1, width clog2(DIV) with a minimum of 1.
- `phi1` is 1 in PHI1; `phi2` is 1 in PHI2.

Transitions, only when `run` = 1:
- `cnt` < DIV-1: `cnt` increments.
- PHI1 with `cnt` = DIV-1: go to PHI2, `cnt` = 0.
- PHI2 with `cnt` = DIV-1 (the sample point): go to PHI1, `cnt` = 0, perform a sample.

At a sample, each lane i is updated as follows:
- Driven (`bus_driven[i]` = 1):
  - `hold[i]` = `bus_in[i]`
  - `dcnt[i]` = DECAY
  - `float_hold[i]` = 0
- Undriven, `dcnt[i]` > 0:
  - `hold[i]` unchanged
  - `dcnt[i]` decrements
  - `float_hold[i]` = 1
- Undriven, `dcnt[i]` = 0:
  - `hold[i]` = 1 (pulled up)
  - `float_hold[i]` = 0
- In all cases, `data_out[i]` takes the new `hold[i]`.

Counter width and saturation:
- `dcnt` is clog2(DECAY+1) bits with a minimum of 1.
- It saturates at 0; it never wraps.

Pulse and stall rules:
- `sample_valid` is 1 for exactly the cycle after a sample and is 0 otherwise.
- When `run` = 0: `cnt`, state, `hold`, `dcnt`, `data_out` and `float_hold` all hold their values, and `sample_valid` is 0.
- If `run` falls on the sample-point cycle, no sample occurs; the sample happens on the first cycle `run` is high again.
- `bus_in` and `bus_driven` are ignored outside the sample point.

## Timing

Reset values, applied asynchronously while `rst_n` = 0:
- State PHI1, `cnt` = 0.
- `phi1` = 1, `phi2` = 0.
- `data_out` = all ones, `hold` = all ones.
- `dcnt` = 0, `float_hold` = 0, `sample_valid` = 0.

Cycle-level behaviour:
- Reset asserted mid-phase aborts the phase immediately, with no partial sample.
- With `run` held high, the phase period is 2×DIV clocks.
- The first `sample_valid` rises on the 2×DIV-th rising edge after reset release.
- Sample latency: the inputs present at the sample-point edge appear on `data_out` in the same edge's result, so `data_out` and `sample_valid` update together.
- `phi1`/`phi2` change on the same edge as the state. There is no dead cycle between phases; non-overlap is guaranteed because both come from a single state bit.
- DIV = 1 is legal: the phase alternates every clock and samples occur every 2 clocks.

## Configuration

`BUS_FLOAT_HOLD_EN`:
- Defined: charge retention operates as described in Operation.
- Undefined:
  - `dcnt` logic is removed.
  - At each sample, `data_out` = `bus_in`, so undriven lanes read as 1 via the lanes' pull-up.
  - `float_hold` is tied to 0.
  - Sequencing and timing are unchanged.

## Test plan

1. Reset, with W=8, DIV=2 and `run` high: during reset `phi1`=1, `data_out`=0xFF, `float_hold`=0x00. After release:
   - `phi1` lasts 2 clocks, then `phi2` lasts 2 clocks.
   - `sample_valid` pulses on the 4th edge and every 4 clocks after that.
2. Driven sample: `bus_driven`=0xFF, `bus_in`=0xA5 at the sample point -> `data_out`=0xA5, `float_hold`=0x00, `sample_valid`=1 for one clock.
3. Retention with DECAY=3 and the macro defined: drive 0x3C, then set `bus_driven`=0x00 (`bus_in`=0xFF):
   - The next 3 samples give `data_out`=0x3C and `float_hold`=0xFF.
   - The 4th sample gives 0xFF and `float_hold`=0x00.
   - Re-driving 0x00 restores DECAY.
4. Mixed lanes: `bus_driven`=0x0F, `bus_in`=0xF2 after a driven 0x55 -> `data_out`=0x52, `float_hold`=0xF0.
5. Stall: drop `run` at the sample-point cycle for 5 clocks -> `phi2` stays 1, there is no pulse and `data_out` is unchanged. The sample occurs on the first clock with `run` high.
6. Macro undefined: repeat scenario 3 -> the first undriven sample gives `data_out`=0xFF and `float_hold`=0x00. Also assert `rst_n` low mid-PHI2 -> all outputs return to their reset values immediately.
